// File: rtl/btn_pkg.sv
// Shared constants, types and helpers for the push-button front end.
package btn_pkg;

  localparam int DEB_10MS = 1_000_000;
  localparam int LONG_1S  = 100_000_000;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic long_press;
    logic led;
  } chan_out_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter debounce, edge pulses,
// long-press detector and toggle latch. Every output is a flop.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter int TOGGLE_ON_LONG  = 0
) (
  input  logic      clk,
  input  logic      srst,
  input  logic      btn,
  input  logic      clr_toggle,
  output chan_out_t status
);

  localparam int CNT_W  = clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              long_q, long_d;
  logic              led_q, led_d;
  logic              toggle_ev;

  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    long_d  = 1'b0;
    led_d   = led_q;

    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Saturating at LONG_CYCLES makes the pulse fire only once per press.
    if (rise_d) begin
      hold_d = '0;
    end else if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_LAST);
    end

    toggle_ev = (TOGGLE_ON_LONG != 0) ? long_d : rise_d;
    if (clr_toggle) begin
      led_d = 1'b0;
    end else if (toggle_ev) begin
      led_d = ~led_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      led_q   <= led_d;
    end
  end

  assign status.level      = level_q;
  assign status.rise       = rise_q;
  assign status.fall       = fall_q;
  assign status.long_press = long_q;
  assign status.led        = led_q;

endmodule

// File: rtl/btn_toggle_multi.sv
// Multi-channel push-button front end: N_CH independent btn_chan instances
// taking raw asynchronous buttons straight from the board.
module btn_toggle_multi
  import btn_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter int TOGGLE_ON_LONG  = 0
) (
  input  logic            clk_100Mhz,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] clr_toggle,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] led
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    chan_out_t status;

    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .TOGGLE_ON_LONG (TOGGLE_ON_LONG)
    ) u_chan (
      .clk       (clk_100Mhz),
      .srst      (rst),
      .btn       (btn[gi]),
      .clr_toggle(clr_toggle[gi]),
      .status    (status)
    );

    assign btn_level[gi]  = status.level;
    assign btn_rise[gi]   = status.rise;
    assign btn_fall[gi]   = status.fall;
    assign long_press[gi] = status.long_press;
    assign led[gi]        = status.led;
  end

endmodule
